uart_baud_prescaler: RTL and testbench
======================================

# uart_baud_prescaler

Programmable baud-rate generator for the UART transmitter and receiver. It replaces the fixed power-of-two clock divider. The divisor is selected at run time, with an optional fractional trim. The block produces three outputs from one clock domain: a single-cycle oversampling tick for the receiver, a single-cycle baud tick for the transmitter, and a baud-rate square wave for debug and legacy consumers. Divisor changes are glitch-free and take effect at period boundaries.

## Interface
- `DIV_WIDTH`, 16: width of the integer divisor.
- `FRAC_WIDTH`, 4: width of the fractional trim, in 1/2^FRAC_WIDTH cycle units.
- `OVERSAMPLE`, 16: oversampling ticks per baud period; must be an even number ≥ 2.
- `DEFAULT_DIVISOR`, 27: integer divisor active after reset (50 MHz / (115200·16) ≈ 27.13).
- `DEFAULT_FRAC`, 2: fractional trim active after reset.

Ports (one clock; reset is synchronous and active-high):
- `fast_clock`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `enable`, in, 1: run when 1; freeze all state when 0.
- `load`, in, 1: one-cycle strobe that captures `divisor` and `frac` into the pending registers.
- `divisor`, in, DIV_WIDTH: requested integer divisor, in fast_clock cycles per oversampling tick.
- `frac`, in, FRAC_WIDTH: requested fractional trim.
- `os_tick`, out, 1: registered one-cycle pulse at the oversampling rate.
- `baud_tick`, out, 1: registered one-cycle pulse, once per OVERSAMPLE os_ticks.
- `slow_clock`, out, 1: registered square wave at the baud rate.
- `pending`, out, 1: high while a loaded divisor is waiting to be applied.

## Operation
- **Active registers:** `act_div` and `act_frac` hold the divisor in use. They reset to DEFAULT_DIVISOR and DEFAULT_FRAC.
- **Load:** `load` copies `divisor`/`frac` into the pending registers and sets `pending`. A second `load` before the pending value is applied overwrites it; the last value wins.
- **Divisor zero:** a loaded `divisor` of 0 is stored as 1.
- **Period counter:** down-counter `cnt`, DIV_WIDTH+1 bits.
  - When `cnt==0` and `enable`, `os_tick` is pulsed.
  - On that same edge, the pending values (if any) are first copied to `act_*`, and `pending` is cleared.
  - `cnt` is then reloaded with `act_div-1+carry`, where `carry` comes from the fractional accumulator.
- **Fractional accumulator:** FRAC_WIDTH bits plus a carry. On every os_tick it computes `acc + act_frac`.
  - A carry-out lengthens the next period by one cycle.
  - Over 2^FRAC_WIDTH consecutive os_ticks, exactly `act_frac` periods are `act_div+1` cycles long; the rest are `act_div` cycles.
- **Oversample counter:** `os_cnt` runs 0..OVERSAMPLE-1 and advances on each os_tick.
  - When it wraps from OVERSAMPLE-1 to 0, `baud_tick` is pulsed in the same cycle as that os_tick.
  - `slow_clock` is 1 while `os_cnt < OVERSAMPLE/2`, otherwise 0, giving a 50 % duty cycle in os_tick units.
- **Enable low:** `cnt`, `acc` and `os_cnt` hold, and `os_tick`/`baud_tick` stay 0. `slow_clock` holds its level. `load` is still accepted. Operation resumes exactly where it stopped.
- **Reset:** every register is cleared or set to its default on the clock edge with `rst=1`. Reset overrides `load` and `enable` when they are asserted in the same cycle. Reset may arrive mid-period and the block restarts cleanly.

## Timing
- **Reset values:**
  - `os_tick` = 0, `baud_tick` = 0, `pending` = 0.
  - `slow_clock` = 1 (`os_cnt` = 0).
  - `cnt` = DEFAULT_DIVISOR-1, `acc` = 0.
- **First os_tick:** with `enable=1` from reset release and frac=0, it is asserted on the D-th rising edge after the last reset edge. Thereafter the os_tick period is exactly D cycles.
- **Divisor 1:** os_tick is high every cycle. `baud_tick` is high one cycle in every OVERSAMPLE.
- **Output latency:** `baud_tick` coincides with the os_tick that ends an oversample frame. `slow_clock` changes on the edge after the os_tick that moves `os_cnt` across OVERSAMPLE/2 or wraps it.
- **Load timing:** a new divisor is first used for the period that starts after the next os_tick. The current period is never truncated or extended.
- **Load coinciding with os_tick:** the new value goes to pending and is applied at the following os_tick.

## Structure
- Shared `uart_defs.vh`:
  - DEFAULT_DIVISOR and DEFAULT_FRAC for the standard 50 MHz / 115200 configuration.
  - OVERSAMPLE, shared with the receiver's mid-bit sampler.
- Sub-module `frac_accumulator`: FRAC_WIDTH-bit accumulator with `step`, `frac_in`, `carry_out` and synchronous reset.
- The top-level block owns the period counter, oversample counter, pending logic and output registers.

## Test plan
- **Reset release:** defaults D=27, frac=0 forced, `enable=1` → first os_tick at edge 27; periods are 27 cycles; `baud_tick` every 432 cycles; `slow_clock` high for 216 cycles, low for 216.
- **Fractional trim:** `load` with divisor=27, frac=2 → over 16 os_ticks, exactly 2 periods of 28 and 14 of 27, for 434 cycles in total.
- **Load mid-period:** `load` with divisor=10 at cycle 5 of a 27-cycle period → that period still ends at 27; next period is 10; `pending` is high from cycle 6 until that os_tick.
- **Edge cases:** `divisor=0` loaded → os_tick every cycle. Back-to-back loads of 8 then 12 → only 12 is applied.
- **Enable low:** `enable` low for 50 cycles mid-period → no ticks; `slow_clock` holds; the remaining count resumes unchanged.
- **Reset mid-operation:** `rst` asserted at `os_cnt=9` together with `load` → all reset values, defaults active, `pending=0`.

Source files
------------

// File: rtl/uart_baud_prescaler_pkg.sv
// Shared UART timing constants: 50 MHz system clock, 115200 baud, 16x oversampling.
// The receiver's mid-bit sampler imports the same OVERSAMPLE_C.
package uart_baud_prescaler_pkg;

  localparam int OVERSAMPLE_C      = 16;
  localparam int DEFAULT_DIVISOR_C = 27;
  localparam int DEFAULT_FRAC_C    = 2;

endpackage

// File: rtl/frac_accumulator.sv
// Fractional phase accumulator; carry_out reports whether the current step
// overflows, so the caller can lengthen the period it is about to start.
module frac_accumulator #(
  parameter int FRAC_WIDTH = 4
) (
  input  logic                  fast_clock,
  input  logic                  rst,
  input  logic                  step,
  input  logic [FRAC_WIDTH-1:0] frac_in,
  output logic                  carry_out
);

  logic [FRAC_WIDTH-1:0] acc_q;
  logic [FRAC_WIDTH:0]   sum;

  assign sum       = {1'b0, acc_q} + {1'b0, frac_in};
  assign carry_out = sum[FRAC_WIDTH];

  always_ff @(posedge fast_clock) begin
    if (rst)       acc_q <= '0;
    else if (step) acc_q <= sum[FRAC_WIDTH-1:0];
  end

endmodule

// File: rtl/uart_baud_prescaler.sv
// Programmable baud generator: os_tick every divisor(+frac) cycles, baud_tick
// once per OVERSAMPLE os_ticks, and a 50 % duty baud-rate square wave.
module uart_baud_prescaler
  import uart_baud_prescaler_pkg::*;
#(
  parameter int DIV_WIDTH       = 16,
  parameter int FRAC_WIDTH      = 4,
  parameter int OVERSAMPLE      = OVERSAMPLE_C,
  parameter int DEFAULT_DIVISOR = DEFAULT_DIVISOR_C,
  parameter int DEFAULT_FRAC    = DEFAULT_FRAC_C
) (
  input  logic                  fast_clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic                  slow_clock,
  output logic                  pending
);

  localparam int CW  = DIV_WIDTH + 1;
  localparam int OSW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [OSW-1:0]        OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0]        OS_HALF  = OSW'(OVERSAMPLE / 2);
  localparam logic [DIV_WIDTH-1:0]  DEF_DIV  = DIV_WIDTH'(DEFAULT_DIVISOR);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC = FRAC_WIDTH'(DEFAULT_FRAC);
  localparam logic [CW-1:0]         CNT_RST  = CW'(DEFAULT_DIVISOR - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [OSW-1:0]        os_cnt_q, os_cnt_d;
  logic [DIV_WIDTH-1:0]  act_div_q, act_div_d, pend_div_q, pend_div_d;
  logic [FRAC_WIDTH-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic                  pending_q, pending_d;
  logic                  os_tick_q, baud_tick_q, slow_q;

  logic                  tick;
  logic                  carry;
  logic                  os_last;
  logic [DIV_WIDTH-1:0]  ld_div;

  assign tick    = enable && (cnt_q == '0);
  assign os_last = (os_cnt_q == OS_LAST);
  // A zero divisor would stall the counter; treat it as the fastest rate.
  assign ld_div  = (divisor == '0) ? DIV_WIDTH'(1) : divisor;

  frac_accumulator #(.FRAC_WIDTH(FRAC_WIDTH)) u_frac (
    .fast_clock (fast_clock),
    .rst        (rst),
    .step       (tick),
    .frac_in    (act_frac_d),
    .carry_out  (carry)
  );

  always_comb begin
    act_div_d   = act_div_q;
    act_frac_d  = act_frac_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    os_cnt_d    = os_cnt_q;

    // Pending values are promoted at the tick so the period being started
    // (and its fractional carry) already uses the new divisor.
    if (tick && pending_q) begin
      act_div_d  = pend_div_q;
      act_frac_d = pend_frac_q;
      pending_d  = 1'b0;
    end

    if (tick) begin
      cnt_d    = CW'(act_div_d) - CW'(1) + CW'(carry);
      os_cnt_d = os_last ? '0 : os_cnt_q + OSW'(1);
    end else if (enable) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A load coinciding with a tick lands in pending for the following tick.
    if (load) begin
      pend_div_d  = ld_div;
      pend_frac_d = frac;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge fast_clock) begin
    if (rst) begin
      cnt_q       <= CNT_RST;
      os_cnt_q    <= '0;
      act_div_q   <= DEF_DIV;
      act_frac_q  <= DEF_FRAC;
      pend_div_q  <= DEF_DIV;
      pend_frac_q <= DEF_FRAC;
      pending_q   <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      slow_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      os_cnt_q    <= os_cnt_d;
      act_div_q   <= act_div_d;
      act_frac_q  <= act_frac_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      pending_q   <= pending_d;
      os_tick_q   <= tick;
      baud_tick_q <= tick && os_last;
      slow_q      <= (os_cnt_q < OS_HALF);
    end
  end

  assign os_tick    = os_tick_q;
  assign baud_tick  = baud_tick_q;
  assign slow_clock = slow_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_uart_baud_prescaler.sv
// Self-checking bench: tick schedule model in absolute enabled-cycle time.
module tb_uart_baud_prescaler;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, ld = 1'b0;
  logic [15:0] div = '0;
  logic [3:0]  fr = '0;
  logic        os_tick, baud_tick, slow_clock, pending;

  uart_baud_prescaler dut (
    .fast_clock (clk),
    .rst        (rst),
    .enable     (en),
    .load       (ld),
    .divisor    (div),
    .frac       (fr),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .slow_clock (slow_clock),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc_no = 0;

  // Model: ecyc counts enabled cycles since reset; next tick scheduled at an
  // absolute ecyc, each period = divisor + carry of the fractional sum.
  int ecyc, next_tick, ntick, acc, a_div, a_frac, p_div, p_frac;
  bit p_v, e_os, e_bd, e_sc, e_pd;

  function automatic void model_edge();
    if (rst) begin
      ecyc = 0; next_tick = 27; ntick = 0; acc = 0;
      a_div = 27; a_frac = 2; p_v = 0;
      e_os = 0; e_bd = 0; e_sc = 1; e_pd = 0;
      return;
    end
    e_sc = ((ntick % OS) < OS / 2);
    e_os = 0; e_bd = 0;
    if (en) begin
      ecyc++;
      if (ecyc == next_tick) begin
        if (p_v) begin a_div = p_div; a_frac = p_frac; p_v = 0; end
        acc = acc + a_frac;
        next_tick = next_tick + a_div + ((acc >= 16) ? 1 : 0);
        acc = acc % 16;
        ntick++;
        e_os = 1;
        e_bd = (ntick % OS == 0);
      end
    end
    if (ld) begin
      p_div = (div == 0) ? 1 : int'(div);
      p_frac = int'(fr);
      p_v = 1;
    end
    e_pd = p_v;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
    model_edge();
    cyc_no++;
  endtask

  task automatic load_apply(input int d, input int f);
    ld = 1; div = 16'(d); fr = 4'(f);
    cyc();
    ld = 0;
    for (int k = 0; k < 300 && pending; k++) cyc();
    n_chk++;
    if (pending !== 1'b0) begin
      n_fail++; $display("FAIL load_apply_timeout pending=%b want 0", pending);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; ld = 1; div = 5;
    repeat (3) cyc();
    ld = 0;
    n_chk += 4;
    if (os_tick !== 1'b0)    begin n_fail++; $display("FAIL reset_os_tick got %b want 0", os_tick); end
    if (baud_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_baud_tick got %b want 0", baud_tick); end
    if (slow_clock !== 1'b1) begin n_fail++; $display("FAIL reset_slow_clock got %b want 1", slow_clock); end
    if (pending !== 1'b0)    begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
  endtask

  task automatic test_reset_release();
    int first_os = 0, first_bd = 0, first_lo = 0, first_hi2 = 0, nos = 0;
    ld = 1; div = 27; fr = 0; rst = 0; en = 1;
    for (int k = 1; k <= 900; k++) begin
      cyc();
      ld = 0;
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL release_vec cyc %0d got %b want %b", k,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
      if (os_tick) nos++;
      if (os_tick && first_os == 0) first_os = k;
      if (baud_tick && first_bd == 0) first_bd = k;
      if (!slow_clock && first_lo == 0) first_lo = k;
      if (slow_clock && first_lo != 0 && first_hi2 == 0) first_hi2 = k;
    end
    n_chk += 5;
    if (first_os != 27)   begin n_fail++; $display("FAIL release_first_os got %0d want 27", first_os); end
    if (first_bd != 432)  begin n_fail++; $display("FAIL release_first_baud got %0d want 432", first_bd); end
    if (first_lo != 217)  begin n_fail++; $display("FAIL release_slow_fall got %0d want 217", first_lo); end
    if (first_hi2 != 433) begin n_fail++; $display("FAIL release_slow_rise got %0d want 433", first_hi2); end
    if (nos != 33)        begin n_fail++; $display("FAIL release_tick_count got %0d want 33", nos); end
  endtask

  task automatic test_frac();
    int last, sum = 0, n28 = 0, nt = 0;
    load_apply(27, 2);
    last = cyc_no;
    for (int k = 0; k < 600 && nt < 16; k++) begin
      cyc();
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL frac_vec cyc %0d got %b want %b", cyc_no,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
      if (os_tick) begin
        if (cyc_no - last == 28) n28++;
        sum += cyc_no - last; last = cyc_no; nt++;
      end
    end
    n_chk += 2;
    if (sum != 434) begin n_fail++; $display("FAIL frac_total got %0d want 434", sum); end
    if (n28 != 2)   begin n_fail++; $display("FAIL frac_long_periods got %0d want 2", n28); end
  endtask

  task automatic test_load_mid();
    int t0, t1 = 0, t2 = 0, pcnt = 0;
    load_apply(27, 0);
    t0 = cyc_no;
    repeat (5) cyc();
    ld = 1; div = 10; fr = 0;
    cyc();
    ld = 0;
    for (int k = 0; k < 60 && t2 == 0; k++) begin
      if (t1 == 0 && pending) pcnt++;
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL loadmid_vec cyc %0d got %b want %b", cyc_no,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
      if (os_tick) begin if (t1 == 0) t1 = cyc_no; else t2 = cyc_no; end
      if (t2 == 0) cyc();
    end
    n_chk += 3;
    if (t1 - t0 != 27) begin n_fail++; $display("FAIL loadmid_cur_period got %0d want 27", t1 - t0); end
    if (t2 - t1 != 10) begin n_fail++; $display("FAIL loadmid_new_period got %0d want 10", t2 - t1); end
    if (pcnt != 21)    begin n_fail++; $display("FAIL loadmid_pending_cycles got %0d want 21", pcnt); end
  endtask

  task automatic test_div0();
    int nos = 0, nbd = 0;
    load_apply(0, 0);
    repeat (48) begin
      cyc();
      if (os_tick) nos++;
      if (baud_tick) nbd++;
    end
    n_chk += 2;
    if (nos != 48) begin n_fail++; $display("FAIL div0_os_ticks got %0d want 48", nos); end
    if (nbd != 3)  begin n_fail++; $display("FAIL div0_baud_ticks got %0d want 3", nbd); end
  endtask

  task automatic test_back_to_back();
    int last, per[2], nt = 0;
    ld = 1; div = 8; fr = 0; cyc();
    div = 12; cyc();
    ld = 0;
    for (int k = 0; k < 100 && pending; k++) cyc();
    last = cyc_no;
    for (int k = 0; k < 100 && nt < 2; k++) begin
      cyc();
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL b2b_vec cyc %0d got %b want %b", cyc_no,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
      if (os_tick) begin per[nt] = cyc_no - last; last = cyc_no; nt++; end
    end
    n_chk += 2;
    if (nt < 2 || per[0] != 12) begin n_fail++; $display("FAIL b2b_period0 got %0d want 12", per[0]); end
    if (nt < 2 || per[1] != 12) begin n_fail++; $display("FAIL b2b_period1 got %0d want 12", per[1]); end
  endtask

  task automatic test_enable();
    int bad = 0, k;
    logic s;
    load_apply(27, 0);
    repeat (10) cyc();
    en = 0; s = slow_clock;
    repeat (50) begin
      cyc();
      if (os_tick || baud_tick || slow_clock !== s) bad++;
    end
    en = 1;
    for (k = 1; k <= 40; k++) begin
      cyc();
      if (os_tick) break;
    end
    n_chk += 2;
    if (bad != 0) begin n_fail++; $display("FAIL enable_hold got %0d bad cycles want 0", bad); end
    if (k != 17)  begin n_fail++; $display("FAIL enable_resume got %0d want 17", k); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      div = 16'($urandom_range(0, 12));
      fr  = 4'($urandom);
      cyc();
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL random_vec cyc %0d got %b want %b", cyc_no,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
    end
    en = 1; ld = 0; rst = 0;
  endtask

  task automatic test_reset_mid();
    int k, first = 0;
    load_apply(3, 0);
    for (k = 0; k < 500 && (ntick % OS) != 9; k++) cyc();
    rst = 1; ld = 1; div = 5;
    cyc();
    n_chk += 4;
    if (os_tick !== 1'b0)    begin n_fail++; $display("FAIL rstmid_os_tick got %b want 0", os_tick); end
    if (baud_tick !== 1'b0)  begin n_fail++; $display("FAIL rstmid_baud_tick got %b want 0", baud_tick); end
    if (slow_clock !== 1'b1) begin n_fail++; $display("FAIL rstmid_slow_clock got %b want 1", slow_clock); end
    if (pending !== 1'b0)    begin n_fail++; $display("FAIL rstmid_pending got %b want 0", pending); end
    rst = 0; ld = 0;
    for (k = 1; k <= 60; k++) begin
      cyc();
      n_chk++;
      if ({os_tick, baud_tick, slow_clock, pending} !== {e_os, e_bd, e_sc, e_pd}) begin
        n_fail++; $display("FAIL rstmid_vec cyc %0d got %b want %b", k,
          {os_tick, baud_tick, slow_clock, pending}, {e_os, e_bd, e_sc, e_pd});
      end
      if (os_tick && first == 0) first = k;
    end
    n_chk++;
    if (first != 27) begin n_fail++; $display("FAIL rstmid_first_os got %0d want 27", first); end
  endtask

  initial begin
    model_edge();
    test_reset();
    test_reset_release();
    test_frac();
    test_load_mid();
    test_div0();
    test_back_to_back();
    test_enable();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
